// File: rtl/qdiv_seq.sv
// qdiv_seq: multi-cycle signed-magnitude Qm.n fixed-point divider.
// Restoring division, one quotient bit per clock, with start/ready/done
// handshake, divide-by-zero detection, saturation and negative-zero cleanup.
// Optional round-half-up on the magnitude when QDIV_ROUND_EN is defined
// (one extra guard iteration, one extra clock of latency).
module qdiv_seq #(
  parameter int Q = 16,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_ready,
  output logic [N-1:0] o_quotient,
  output logic         o_done,
  output logic         o_overflow,
  output logic         o_div_zero
);

`ifdef QDIV_ROUND_EN
  localparam int GUARD = 1;
`else
  localparam int GUARD = 0;
`endif

  // Quotient/numerator width equals the iteration count; the guard bit (if
  // any) sits at the bottom of the quotient.
  localparam int ITER = N - 1 + Q + GUARD;
  localparam int QW   = ITER;
  localparam int CW   = $clog2(ITER + 2);
  localparam int MW   = N + Q;   // magnitude plus room for a rounding carry

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [QW-1:0]   num;     // remaining numerator bits, consumed MSB first
  logic [N-1:0]    rem;     // partial remainder
  logic [QW-1:0]   quo;     // quotient bits accumulated LSB-in
  logic [N-2:0]    dvsr;    // divisor magnitude
  logic            sign;
  logic            dz;

  logic [N:0]      rem_sh;
  logic            ge;
  logic [N-1:0]    rem_nx;
  logic [MW-1:0]   mag_ext;
  logic            ovf;
  logic [N-2:0]    res_mag;
  logic            res_sign;

  // One restoring step: shift in the next numerator bit, trial-subtract.
  always_comb begin
    rem_sh = {rem, num[QW-1]};
    ge     = (rem_sh >= {2'b00, dvsr});
    rem_nx = N'(ge ? (rem_sh - {2'b00, dvsr}) : rem_sh);
  end

  // Result shaping: optional rounding, saturation and negative-zero cleanup.
  always_comb begin
`ifdef QDIV_ROUND_EN
    mag_ext = {1'b0, quo[QW-1:1]} + MW'(quo[0]);
`else
    mag_ext = {1'b0, quo};
`endif
    ovf      = dz | (|mag_ext[MW-1:N-1]);
    res_mag  = ovf ? '1 : mag_ext[N-2:0];
    res_sign = sign & (|res_mag);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      num        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      sign       <= 1'b0;
      dz         <= 1'b0;
      o_ready    <= 1'b1;
      o_quotient <= '0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            num     <= {i_dividend[N-2:0], {(Q+GUARD){1'b0}}};
            dvsr    <= i_divisor[N-2:0];
            sign    <= i_dividend[N-1] ^ i_divisor[N-1];
            rem     <= '0;
            quo     <= '0;
            o_ready <= 1'b0;
            if (i_divisor[N-2:0] == '0) begin
              dz    <= 1'b1;
              cnt   <= '0;
              state <= FINAL;
            end else begin
              dz    <= 1'b0;
              cnt   <= CW'(ITER - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= {quo[QW-2:0], ge};
          num <= num << 1;
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= FINAL;
        end
        FINAL: begin
          o_quotient <= {res_sign, res_mag};
          o_overflow <= ovf;
          o_div_zero <= dz;
          o_done     <= 1'b1;
          o_ready    <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
- Parametrised, multi-cycle signed-magnitude fixed-point divider, Qm.n format: bit N-1 is the sign, the remaining N-1 bits are the magnitude, and the low Q bits are fractional.
- Successor to the fixed 32/16 divider used across the encoder datapath, e.g. LPC/gain normalisation.
- Adds a start/ready/done handshake, divide-by-zero detection, saturation, negative-zero cleanup and optional rounding.
- Computes one quotient bit per clock, using restoring division.

Parameters:
- Q, 16, number of fractional bits (1 <= Q <= N-2)
- N, 32, total word width including the sign bit

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- i_start  input  1  request; accepted only when o_ready=1
- i_dividend  input  N  signed-magnitude Q-format dividend
- i_divisor  input  N  signed-magnitude Q-format divisor
- o_ready  output  1  high in IDLE; a new operation may start
- o_quotient  output  N  signed-magnitude Q-format result; held until the next completion
- o_done  output  1  one-cycle pulse when o_quotient/flags are updated
- o_overflow  output  1  result saturated; valid with o_done, held
- o_div_zero  output  1  divisor magnitude was zero; valid with o_done, held

Behaviour:
- Reset (rst=1 at the edge): state=IDLE, o_ready=1, o_quotient=0, o_done=0, o_overflow=0, o_div_zero=0, counter=0.
- Reset mid-operation aborts: no o_done, outputs return to 0, and o_ready=1 the cycle after.
- States: IDLE, CALC, FINAL.
- IDLE: if i_start at edge T, latch |dividend|, |divisor|, sign = dividend[N-1] XOR divisor[N-1]; o_ready drops after edge T.
  - If |divisor|==0: go directly to FINAL.
  - Otherwise: go to CALC with counter = ITER-1.
- CALC: the working numerator is |dividend| << Q, width N-1+Q. Each cycle:
  - shift the partial remainder left by one and bring in the next numerator bit, MSB first;
  - if remainder >= |divisor|, subtract and shift 1 into the quotient, else shift 0;
  - decrement the counter; on counter==0 go to FINAL.
- ITER = N-1+Q (47 at the defaults).
- FINAL (1 cycle): register the results, pulse o_done, return to IDLE; o_ready=1 the following cycle.
  - div-by-zero: o_quotient = {sign, all ones}, o_overflow=1, o_div_zero=1.
  - Quotient bits above bit N-2 nonzero: o_quotient = {sign, all ones}, o_overflow=1.
  - Otherwise: o_quotient = {sign, quotient[N-2:0]}, flags 0.
  - If the final magnitude is 0, the sign bit is forced to 0. A negative-zero input therefore yields +0.
- Latency (normal): o_done is high in the cycle after edge T+ITER+1, i.e. ITER+2 clocks from acceptance.
- Latency (div-by-zero): o_done is high after edge T+1.
- i_start while o_ready=0 is ignored; inputs are sampled only at acceptance.
- An i_start in the same cycle as the o_done pulse is ignored; o_ready is 0 during FINAL.
- rst has priority over i_start.
- Truncation toward zero of the magnitude; the divider is symmetric for sign.
- Internal widths: remainder N bits, quotient N-1+Q bits, counter $clog2(ITER+2) bits.

Optional Feature:
- Macro QDIV_ROUND_EN.
- Defined:
  - one extra CALC iteration (ITER = N+Q) produces a guard bit;
  - FINAL adds the guard bit to the magnitude, giving round-half-up on the magnitude;
  - if the rounding carry exceeds the N-1-bit range, saturate and set o_overflow;
  - latency +1 clock.
- Undefined: truncation only, ITER = N-1+Q.

Test Plan:
- 0x80048000 (-4.5) / 0x00038000 (3.5) -> o_quotient 0x80014924, flags 0.
  - o_done exactly 49 clocks after acceptance.
  - With QDIV_ROUND_EN: 0x80014925, 50 clocks.
- 0x00010000 (1.0) / 0x80000000 (-0) -> o_quotient 0xFFFFFFFF, o_overflow=1, o_div_zero=1, o_done 2 clocks after acceptance.
- 0x40000000 (16384.0) / 0x00004000 (0.25) -> o_quotient 0x7FFFFFFF, o_overflow=1, o_div_zero=0.
- 0x80000000 (-0) / 0x00020000 (2.0) -> o_quotient 0x00000000 (sign cleared), flags 0.
- Start 0x00030000/0x00010000, assert rst at CALC cycle 10 for 1 clock:
  - no o_done, all outputs 0, o_ready=1 next cycle;
  - restart with the same operands -> 0x00030000 after the full latency.
- Pulse i_start with different operands during CALC and during FINAL -> ignored; the first operation's result is unchanged; exactly one o_done.
